// File: rtl/ctrl_pkg.sv
// Shared definitions for the control/status register bank: bus-cycle state
// encoding, fixed register indices and mapper field widths.
package ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_WAIT = 2'd1,
    CTRL_ACK  = 2'd2,
    CTRL_ERR  = 2'd3
  } ctrl_state_e;

  localparam int REG_SMAP1  = 0;
  localparam int REG_SMAP2  = 1;
  localparam int REG_UMAP   = 2;
  localparam int USER_MAP_W = 4;

  // Wait counter width; covers WAIT_STATES up to 15.
  localparam int WAIT_W = 4;

endpackage

// File: rtl/ctrl_bank_if.sv
// Bus-side request signals of the 68k control region, grouped for the
// register bank. The tristate pins d/dtack/berr stay on the bank itself.
interface ctrl_bank_if #(
  parameter int ADDR_W = 3
);
  // Handshake: the master raises enable with addr/write/lds/uds/supervisor
  // stable and holds all of them until it sees dtack or berr; it then drops
  // enable for at least one clock before starting the next access.
  logic              enable;
  logic              supervisor;
  logic [ADDR_W-1:0] addr;
  logic              lds;
  logic              uds;
  logic              write;

  modport master (output enable, supervisor, addr, lds, uds, write);
  modport slave  (input  enable, supervisor, addr, lds, uds, write);
endinterface

// File: rtl/ctrl_bus_fsm.sv
// Bus-cycle state machine for the register bank: decodes illegal accesses,
// counts wait states and flags the edge on which an access commits.
module ctrl_bus_fsm
  import ctrl_pkg::*;
#(
  parameter int                  NUM_REGS    = 8,
  parameter int                  ADDR_W      = 3,
  parameter int                  WAIT_STATES = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              supervisor_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              write_i,
  output logic              commit_o,
  output logic              dtack_int_o,
  output logic              berr_int_o,
  output ctrl_state_e       state_o
);

  localparam logic [2**ADDR_W-1:0] RO_FULL   = (2**ADDR_W)'(RO_MASK);
  localparam logic [WAIT_W-1:0]    WAIT_INIT = WAIT_W'(WAIT_STATES - 1);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              illegal;

  assign illegal = (int'(addr_i) >= NUM_REGS)
                || (write_i && !supervisor_i)
                || (write_i && RO_FULL[addr_i]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CTRL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CTRL_IDLE: begin
        if (enable_i) begin
          if (illegal) begin
            state_d = CTRL_ERR;
          end else if (WAIT_STATES == 0) begin
            state_d = CTRL_ACK;
          end else begin
            state_d = CTRL_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      CTRL_WAIT: begin
        // An aborted cycle leaves without ever reaching the commit edge.
        if (!enable_i) begin
          state_d = CTRL_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = CTRL_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CTRL_ACK, CTRL_ERR: begin
        if (!enable_i) state_d = CTRL_IDLE;
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  always_comb begin
    commit_o    = (state_d == CTRL_ACK) && (state_q != CTRL_ACK);
    dtack_int_o = (state_q == CTRL_ACK);
    berr_int_o  = (state_q == CTRL_ERR);
    state_o     = state_q;
  end

endmodule

// File: rtl/ctrl_bank.sv
// Parametrised control/status register bank on the 68k data bus, with
// wait states, supervisor write protection, bus errors and write strobes.
module ctrl_bank
  import ctrl_pkg::*;
#(
  parameter int                  NUM_REGS    = 8,
  parameter int                  ADDR_W      = 3,
  parameter int                  WAIT_STATES = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ctrl_bank_if.slave              bus,
  inout  wire  [15:0]             d,
  output wire                     dtack,
  output wire                     berr,
  input  logic [NUM_REGS*16-1:0]  status,
  output logic [NUM_REGS*16-1:0]  regs_out,
  output logic [NUM_REGS-1:0]     reg_wr
);

  localparam logic [2**ADDR_W-1:0] RO_FULL = (2**ADDR_W)'(RO_MASK);

  logic [15:0]         regs_q [NUM_REGS];
  logic [15:0]         regs_d [NUM_REGS];
  logic [15:0]         d_out_q, d_out_d;
  logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;
  logic [15:0]         rd_val;
  logic                commit, dtack_int, berr_int;
  ctrl_state_e         state;

  ctrl_bus_fsm #(
    .NUM_REGS    (NUM_REGS),
    .ADDR_W      (ADDR_W),
    .WAIT_STATES (WAIT_STATES),
    .RO_MASK     (RO_MASK)
  ) u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (bus.enable),
    .supervisor_i (bus.supervisor),
    .addr_i       (bus.addr),
    .write_i      (bus.write),
    .commit_o     (commit),
    .dtack_int_o  (dtack_int),
    .berr_int_o   (berr_int),
    .state_o      (state)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      d_out_q  <= '0;
      reg_wr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      d_out_q  <= d_out_d;
      reg_wr_q <= reg_wr_d;
    end
  end

  always_comb begin
    regs_d   = regs_q;
    d_out_d  = d_out_q;
    reg_wr_d = '0;
    rd_val   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(bus.addr) == i) rd_val = RO_FULL[i] ? status[16*i +: 16] : regs_q[i];
    end
    // Illegal accesses never reach the commit edge, so no range check here.
    if (commit) begin
      if (bus.write) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (int'(bus.addr) == i && (bus.lds || bus.uds)) begin
            if (bus.lds) regs_d[i][7:0]  = d[7:0];
            if (bus.uds) regs_d[i][15:8] = d[15:8];
            reg_wr_d[i] = 1'b1;
          end
        end
      end else begin
        d_out_d = rd_val;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[16*g +: 16] = RO_FULL[g] ? 16'h0000 : regs_q[g];
  end

  assign reg_wr = reg_wr_q;
  assign dtack  = bus.enable ? dtack_int : 1'bz;
  assign berr   = bus.enable ? berr_int  : 1'bz;
  assign d      = (bus.enable && !bus.write && state == CTRL_ACK) ? d_out_q : 16'hzzzz;

endmodule
